// File: rtl/i2c_target_regs_if.sv
// Pin-side and register-file signals of the I2C target, bundled for port hookup.
// The slave modport is the target's view; the master modport is the bus/pad side.
interface i2c_target_regs_if #(
    parameter int unsigned NREGS = 12
);
    logic                 scl_in;
    logic                 sda_in;
    logic                 sda_oe;
    logic [8*NREGS-1:0]   regs;
    logic                 wr_stb;
    logic [3:0]           wr_idx;
    logic                 busy;

    modport slave (
        input  scl_in,
        input  sda_in,
        output sda_oe,
        output regs,
        output wr_stb,
        output wr_idx,
        output busy
    );

    modport master (
        output scl_in,
        output sda_in,
        input  sda_oe,
        input  regs,
        input  wr_stb,
        input  wr_idx,
        input  busy
    );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target at a fixed 7-bit address with a byte-wide register file.
// SDA is open drain: sda_oe=1 pulls the line low, 0 releases it.
module i2c_target_regs #(
    parameter logic [6:0]  ADDR  = 7'h70,
    parameter int unsigned NREGS = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    i2c_target_regs_if.slave  bus
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_WAIT
    } state_t;

    logic       scl_s1, scl_s2, scl_s3;
    logic       sda_s1, sda_s2, sda_s3;
    logic       scl_rise, scl_fall, start_det, stop_det;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [3:0] ptr;
    logic [3:0] ptr_next;
    logic       rw;
    logic       rack_nak;
    logic       sda_oe_q;
    logic       busy_q;
    logic       wr_stb_q;
    logic [3:0] wr_idx_q;
    logic [7:0] mem [NREGS];

    // Two-flop synchronizers plus one history flop for edge detection; idle bus level is 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_s3 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_s3 <= 1'b1;
        end else begin
            scl_s1 <= bus.scl_in;
            scl_s2 <= scl_s1;
            scl_s3 <= scl_s2;
            sda_s1 <= bus.sda_in;
            sda_s2 <= sda_s1;
            sda_s3 <= sda_s2;
        end
    end

    always_comb begin
        scl_rise  = scl_s2 & ~scl_s3;
        scl_fall  = ~scl_s2 & scl_s3;
        start_det = scl_s2 & sda_s3 & ~sda_s2;
        stop_det  = scl_s2 & ~sda_s3 & sda_s2;
        ptr_next  = (ptr == 4'(NREGS - 1)) ? 4'd0 : ptr + 4'd1;
    end

    // Shifting states count rising edges to 8; the byte is acted on at the following
    // falling edge so that sda_oe only ever changes while SCL is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            ptr      <= '0;
            rw       <= 1'b0;
            rack_nak <= 1'b0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            wr_stb_q <= 1'b0;
            wr_idx_q <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            wr_stb_q <= 1'b0;
            if (start_det) begin
                state    <= ST_ADDR;
                bit_cnt  <= '0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b1;
            end else if (stop_det) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (shreg[7:1] == ADDR) begin
                                rw       <= shreg[0];
                                sda_oe_q <= 1'b1;
                                state    <= ST_ADDR_ACK;
                            end else begin
                                busy_q <= 1'b0;
                                state  <= ST_WAIT;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                shreg    <= mem[ptr];
                                sda_oe_q <= ~mem[ptr][7];
                                state    <= ST_RDATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state    <= ST_SUB;
                            end
                        end
                    end
                    ST_SUB: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (shreg < 8'(NREGS)) begin
                                ptr      <= shreg[3:0];
                                sda_oe_q <= 1'b1;
                                state    <= ST_SUB_ACK;
                            end else begin
                                busy_q <= 1'b0;
                                state  <= ST_WAIT;
                            end
                        end
                    end
                    ST_SUB_ACK: begin
                        if (scl_fall) begin
                            bit_cnt  <= '0;
                            sda_oe_q <= 1'b0;
                            state    <= ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt  <= '0;
                            mem[ptr] <= shreg;
                            wr_stb_q <= 1'b1;
                            wr_idx_q <= ptr;
                            ptr      <= ptr_next;
                            sda_oe_q <= 1'b1;
                            state    <= ST_WDATA_ACK;
                        end
                    end
                    ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            bit_cnt  <= '0;
                            sda_oe_q <= 1'b0;
                            state    <= ST_WDATA;
                        end
                    end
                    ST_RDATA: begin
                        // Bit 7 was driven on entry; each later fall presents the next bit.
                        if (scl_rise && bit_cnt != 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt  <= '0;
                            sda_oe_q <= 1'b0;
                            state    <= ST_RACK;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            shreg    <= {shreg[6:0], 1'b0};
                            sda_oe_q <= ~shreg[6];
                        end
                    end
                    ST_RACK: begin
                        if (scl_rise) begin
                            rack_nak <= sda_s2;
                            bit_cnt  <= 4'd1;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            bit_cnt <= '0;
                            if (!rack_nak) begin
                                ptr      <= ptr_next;
                                shreg    <= mem[ptr_next];
                                sda_oe_q <= ~mem[ptr_next][7];
                                state    <= ST_RDATA;
                            end else begin
                                busy_q <= 1'b0;
                                state  <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        sda_oe_q <= 1'b0;
                    end
                    ST_IDLE: begin
                        sda_oe_q <= 1'b0;
                    end
                    default: begin
                        sda_oe_q <= 1'b0;
                        state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regs
        assign bus.regs[8*g +: 8] = mem[g];
    end

    assign bus.sda_oe = sda_oe_q;
    assign bus.busy   = busy_q;
    assign bus.wr_stb = wr_stb_q;
    assign bus.wr_idx = wr_idx_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged initiator drives the bus; register commits
// are checked by a wr_stb monitor against a queue of expected (index, data) pairs.
module tb_i2c_target_regs;

    localparam time Q = 50ns;

    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_line;

    int pass_cnt = 0;
    int total_cnt = 0;
    int oe_cnt = 0;
    wr_t exp_q[$];

    i2c_target_regs_if #(.NREGS(12)) bus ();

    i2c_target_regs #(.ADDR(7'h70), .NREGS(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign sda_line   = sda_m & ~bus.sda_oe;
    assign bus.sda_in = sda_line;
    assign bus.scl_in = scl_m;

    always #5ns clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] reg_at(input int idx);
        return bus.regs[8*idx +: 8];
    endfunction

    // Scoreboard monitor: every wr_stb pulse pops one expected commit.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.sda_oe) oe_cnt++;
            if (bus.wr_stb) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr_stb", 128'(bus.wr_stb), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("wr_idx", 128'(bus.wr_idx), 128'(e.idx));
                    check("wr_data", 128'(reg_at(int'(bus.wr_idx))), 128'(e.data));
                end
            end
        end
    end

    task automatic clk_bit(input logic v, output logic s);
        #Q sda_m = v;
        #Q scl_m = 1'b1;
        #Q s = sda_line;
        #Q scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nak, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(nak, s);
    endtask

    task automatic wr_expect(input logic [3:0] idx, input logic [7:0] data);
        wr_t e;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    initial begin
        logic       ack;
        logic [7:0] b;
        logic [95:0] snap;
        logic [7:0] pre [12] = '{8'hAA, 8'h55, 8'h69, 8'h96, 8'h01, 8'h02,
                                 8'h03, 8'h04, 8'h2B, 8'hFF, 8'h00, 8'h00};

        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_sda_oe", 128'(bus.sda_oe), 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_wr_stb", 128'(bus.wr_stb), 128'(0));
        check("rst_wr_idx", 128'(bus.wr_idx), 128'(0));
        check("rst_regs", 128'(bus.regs), 128'(0));

        // Basic write
        wr_expect(4'd0, 8'hAA);
        wr_expect(4'd1, 8'h55);
        i2c_start();
        #Q check("busy_after_start", 128'(bus.busy), 128'(1));
        write_byte(8'hE0, ack); check("bw_addr_ack", 128'(ack), 128'(1));
        write_byte(8'h00, ack); check("bw_sub_ack", 128'(ack), 128'(1));
        write_byte(8'hAA, ack); check("bw_d0_ack", 128'(ack), 128'(1));
        write_byte(8'h55, ack); check("bw_d1_ack", 128'(ack), 128'(1));
        i2c_stop();
        check("bw_reg0", 128'(reg_at(0)), 128'(8'hAA));
        check("bw_reg1", 128'(reg_at(1)), 128'(8'h55));
        check("bw_busy_after_stop", 128'(bus.busy), 128'(0));

        // Preload all 12 registers, then read back via repeated START
        i2c_start();
        write_byte(8'hE0, ack); check("pl_addr_ack", 128'(ack), 128'(1));
        write_byte(8'h00, ack); check("pl_sub_ack", 128'(ack), 128'(1));
        for (int i = 0; i < 12; i++) begin
            wr_expect(4'(i), pre[i]);
            write_byte(pre[i], ack);
            check("pl_data_ack", 128'(ack), 128'(1));
        end
        i2c_stop();

        i2c_start();
        write_byte(8'hE0, ack); check("rb_addr_ack", 128'(ack), 128'(1));
        write_byte(8'h00, ack); check("rb_sub_ack", 128'(ack), 128'(1));
        i2c_start();
        write_byte(8'hE1, ack); check("rb_raddr_ack", 128'(ack), 128'(1));
        for (int i = 0; i < 12; i++) begin
            read_byte(1'b0, b);
            check("rb_data", 128'(b), 128'(pre[i]));
        end
        // Pointer has wrapped to 0 (0xAA, bit 7 = 1), so SDA is released for the STOP.
        i2c_stop();
        check("rb_busy_after_stop", 128'(bus.busy), 128'(0));

        // Pointer wrap
        wr_expect(4'd11, 8'h2B);
        wr_expect(4'd0, 8'hFF);
        i2c_start();
        write_byte(8'hE0, ack); check("pw_addr_ack", 128'(ack), 128'(1));
        write_byte(8'h0B, ack); check("pw_sub_ack", 128'(ack), 128'(1));
        write_byte(8'h2B, ack); check("pw_d0_ack", 128'(ack), 128'(1));
        write_byte(8'hFF, ack); check("pw_d1_ack", 128'(ack), 128'(1));
        i2c_stop();
        check("pw_reg11", 128'(reg_at(11)), 128'(8'h2B));
        check("pw_reg0", 128'(reg_at(0)), 128'(8'hFF));

        // Wrong address: SDA never pulled, nothing written
        snap = bus.regs;
        oe_cnt = 0;
        i2c_start();
        write_byte(8'hE2, ack); check("ar_addr_nak", 128'(ack), 128'(0));
        write_byte(8'h00, ack); check("ar_sub_nak", 128'(ack), 128'(0));
        write_byte(8'h5A, ack); check("ar_data_nak", 128'(ack), 128'(0));
        i2c_stop();
        check("ar_sda_never_pulled", 128'(oe_cnt), 128'(0));
        check("ar_regs_unchanged", 128'(bus.regs), 128'(snap));

        // Subaddress out of range
        i2c_start();
        write_byte(8'hE0, ack); check("sr_addr_ack", 128'(ack), 128'(1));
        write_byte(8'h0C, ack); check("sr_sub_nak", 128'(ack), 128'(0));
        write_byte(8'h77, ack); check("sr_data_nak", 128'(ack), 128'(0));
        i2c_stop();
        check("sr_regs_unchanged", 128'(bus.regs), 128'(snap));

        // Read two bytes, NAK the second
        i2c_start();
        write_byte(8'hE0, ack); check("rn_addr_ack", 128'(ack), 128'(1));
        write_byte(8'h02, ack); check("rn_sub_ack", 128'(ack), 128'(1));
        i2c_start();
        write_byte(8'hE1, ack); check("rn_raddr_ack", 128'(ack), 128'(1));
        read_byte(1'b0, b); check("rn_byte0", 128'(b), 128'(8'h69));
        read_byte(1'b1, b); check("rn_byte1", 128'(b), 128'(8'h96));
        oe_cnt = 0;
        read_byte(1'b1, b);
        check("rn_released_after_nak", 128'(oe_cnt), 128'(0));
        check("rn_line_high_after_nak", 128'(b), 128'(8'hFF));
        i2c_stop();
        i2c_start();
        #Q check("rn_busy_next_start", 128'(bus.busy), 128'(1));
        write_byte(8'hE0, ack); check("rn_next_addr_ack", 128'(ack), 128'(1));
        write_byte(8'h05, ack); check("rn_next_sub_ack", 128'(ack), 128'(1));
        i2c_stop();

        // Reset while the target drives bit 7 (0) of regs[4]=0x01
        i2c_start();
        write_byte(8'hE0, ack); check("mr_addr_ack", 128'(ack), 128'(1));
        write_byte(8'h04, ack); check("mr_sub_ack", 128'(ack), 128'(1));
        i2c_start();
        write_byte(8'hE1, ack); check("mr_raddr_ack", 128'(ack), 128'(1));
        #70ns check("mr_driving_zero", 128'(bus.sda_oe), 128'(1));
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1 check("mr_sda_oe", 128'(bus.sda_oe), 128'(0));
        check("mr_busy", 128'(bus.busy), 128'(0));
        check("mr_regs", 128'(bus.regs), 128'(0));
        @(negedge clk) rst_n = 1'b1;
        i2c_stop();
        check("mr_busy_after_stop", 128'(bus.busy), 128'(0));

        repeat (10) @(negedge clk);
        check("wr_queue_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, %0d/%0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule
